// File: rtl/cam_frame_capture.sv
// Single-frame capture from the camera pixel bus into a 16-bit frame buffer.
// Byte pairs are packed low-first and written as a one-cycle strobe stream.
module cam_frame_capture #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_LINES  = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_trigger,
  input  logic                  cvclk,
  input  logic                  cvsync,
  input  logic                  chsync,
  input  logic [7:0]            ycbcr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  capture_done,
  output logic                  overflow,
  output logic [9:0]            line_count,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [ADDR_WIDTH:0] CAP =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [9:0] LMAX = 10'(MAX_LINES);

  logic [1:0] state;
  logic       clk_s1, clk_s2, clk_s3;
  logic       vs_s1, vs_s2, vs_p;
  logic       hs_s1, hs_s2, hs_p;
  logic [7:0] px_s1, px_s2;
  logic       trig_p;
  logic       pending;
  logic [7:0] low;

  logic        pix_ev, vs_rise, vs_fall, hs_fall;
  logic        trig_rise, take, line_end, word_rdy;
  logic [15:0] word;

  assign pix_ev    = clk_s2 & ~clk_s3;
  assign vs_rise   = vs_s2 & ~vs_p;
  assign vs_fall   = ~vs_s2 & vs_p;
  assign hs_fall   = ~hs_s2 & hs_p;
  assign trig_rise = capture_trigger & ~trig_p;

  // A frame ending while the line is still open closes that line too
  assign take     = pix_ev & hs_s2 & vs_s2;
  assign line_end = hs_fall | (vs_fall & hs_s2);
  assign word_rdy = pending & (take | line_end);
  assign word     = take ? {px_s2, low} : {8'h00, low};

  assign busy = (state == ARMED) | (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clk_s1       <= 1'b0;
      clk_s2       <= 1'b0;
      clk_s3       <= 1'b0;
      vs_s1        <= 1'b0;
      vs_s2        <= 1'b0;
      vs_p         <= 1'b0;
      hs_s1        <= 1'b0;
      hs_s2        <= 1'b0;
      hs_p         <= 1'b0;
      px_s1        <= 8'h00;
      px_s2        <= 8'h00;
      trig_p       <= 1'b0;
      pending      <= 1'b0;
      low          <= 8'h00;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 16'h0000;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
      line_count   <= 10'd0;
      word_count   <= '0;
    end else begin
      clk_s1 <= cvclk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      vs_s1  <= cvsync;
      vs_s2  <= vs_s1;
      vs_p   <= vs_s2;
      hs_s1  <= chsync;
      hs_s2  <= hs_s1;
      hs_p   <= hs_s2;
      px_s1  <= ycbcr;
      px_s2  <= px_s1;
      trig_p <= capture_trigger;
      wr_en  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (trig_rise) begin
            state        <= ARMED;
            capture_done <= 1'b0;
            overflow     <= 1'b0;
            line_count   <= 10'd0;
            word_count   <= '0;
            wr_addr      <= '0;
            pending      <= 1'b0;
          end
        end
        ARMED: begin
          if (vs_rise) begin
            state   <= CAPTURE;
            pending <= 1'b0;
          end
        end
        CAPTURE: begin
          if (take && !pending) begin
            low     <= px_s2;
            pending <= 1'b1;
          end
          if (word_rdy) begin
            pending <= 1'b0;
            // Full buffer: drop the word, never wrap the address
            if (word_count == CAP) begin
              overflow <= 1'b1;
            end else begin
              wr_en      <= 1'b1;
              wr_data    <= word;
              wr_addr    <= word_count[ADDR_WIDTH-1:0];
              word_count <= word_count + 1'b1;
            end
          end
          if (line_end && line_count != LMAX) begin
            line_count <= line_count + 10'd1;
          end
          if (vs_fall) begin
            state <= DONE;
          end
        end
        DONE: begin
          capture_done <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Self-checking bench for cam_frame_capture: table vectors, random frames
// against a line-level packing model, and hand-written corner sequences.
module tb_cam_frame_capture;

  localparam int AW   = 8;
  localparam int ML   = 5;
  localparam int CAPW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          capture_trigger = 1'b0;
  logic          cvclk = 1'b0;
  logic          cvsync = 1'b0;
  logic          chsync = 1'b0;
  logic [7:0]    ycbcr = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          capture_done;
  logic          overflow;
  logic [9:0]    line_count;
  logic [AW:0]   word_count;

  cam_frame_capture #(.ADDR_WIDTH(AW), .MAX_LINES(ML)) dut (
    .clk(clk),
    .reset(reset),
    .capture_trigger(capture_trigger),
    .cvclk(cvclk),
    .cvsync(cvsync),
    .chsync(chsync),
    .ycbcr(ycbcr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .capture_done(capture_done),
    .overflow(overflow),
    .line_count(line_count),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nl;
    int          len;
    bit          open_end;
    int          exp_words;
    int          exp_lines;
    bit          exp_ovf;
    logic [15:0] exp_w0;
  } vec_t;

  vec_t tbl[8];

  int tests = 0;
  int fails = 0;

  logic [AW+15:0] got_q[$];
  logic [AW+15:0] exp_q[$];
  logic [7:0]     bytes_q[$];
  int             lens_q[$];

  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One camera pixel clock period, 6 system clocks
  task automatic pix(input logic [7:0] b, input logic hs);
    cvclk  = 1'b0;
    ycbcr  = b;
    chsync = hs;
    repeat (3) @(negedge clk);
    cvclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic blank();
    pix(8'($urandom), 1'b0);
  endtask

  task automatic arm();
    @(negedge clk);
    capture_trigger = 1'b1;
    @(negedge clk);
    capture_trigger = 1'b0;
    @(negedge clk);
    got_q.delete();
  endtask

  task automatic load_uniform(input int nl, input int len);
    bytes_q.delete();
    lens_q.delete();
    for (int l = 0; l < nl; l++) begin
      lens_q.push_back(len);
      for (int j = 0; j < len; j++) bytes_q.push_back(8'(j));
    end
  endtask

  task automatic load_random();
    int nl;
    bytes_q.delete();
    lens_q.delete();
    nl = $urandom_range(1, 7);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = $urandom_range(1, 40);
      lens_q.push_back(len);
      for (int j = 0; j < len; j++) bytes_q.push_back(8'($urandom));
    end
  endtask

  // Packing rule stated per line: pairs low-first, a lone tail byte padded
  task automatic build_model(output int nw, output int nlc,
                             output bit ovf);
    int p;
    logic [15:0] w;
    exp_q.delete();
    ovf = 1'b0;
    p = 0;
    foreach (lens_q[l]) begin
      for (int j = 0; j < lens_q[l]; j += 2) begin
        if (j + 1 < lens_q[l]) w = {bytes_q[p+j+1], bytes_q[p+j]};
        else w = {8'h00, bytes_q[p+j]};
        if (exp_q.size() < CAPW)
          exp_q.push_back({AW'(exp_q.size()), w});
        else
          ovf = 1'b1;
      end
      p += lens_q[l];
    end
    nw  = exp_q.size();
    nlc = (lens_q.size() > ML) ? ML : lens_q.size();
  endtask

  task automatic run_frame(input bit open_end, input int trig_line);
    int p;
    p = 0;
    cvsync = 1'b0;
    blank();
    cvsync = 1'b1;
    blank();
    blank();
    foreach (lens_q[l]) begin
      if (l == trig_line) capture_trigger = 1'b1;
      for (int j = 0; j < lens_q[l]; j++) pix(bytes_q[p+j], 1'b1);
      capture_trigger = 1'b0;
      p += lens_q[l];
      if (open_end && l == lens_q.size() - 1) begin
        cvsync = 1'b0;
        pix(8'h00, 1'b1);
      end
      blank();
      blank();
    end
    cvsync = 1'b0;
    blank();
    blank();
    blank();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!capture_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done"}, 32'(capture_done), 32'd1);
    chk({nm, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic cmp_stream(input string nm);
    int bad;
    bad = -1;
    if (got_q.size() != exp_q.size()) begin
      bad = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    end else begin
      foreach (exp_q[i]) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s stream: %0d writes vs %0d expected, first diff at %0d",
               nm, got_q.size(), exp_q.size(), bad);
    end
  endtask

  task automatic check_frame(input string nm);
    int nw, nlc;
    bit ovf;
    build_model(nw, nlc, ovf);
    wait_done(nm);
    cmp_stream(nm);
    chk({nm, " words"}, 32'(word_count), 32'(nw));
    chk({nm, " lines"}, 32'(line_count), 32'(nlc));
    chk({nm, " ovf"}, 32'(overflow), 32'(ovf));
  endtask

  initial begin
    tbl[0] = '{3, 5, 1'b0, 9, 3, 1'b0, 16'h0100};
    tbl[1] = '{4, 4, 1'b0, 8, 4, 1'b0, 16'h0100};
    tbl[2] = '{2, 1, 1'b0, 2, 2, 1'b0, 16'h0000};
    tbl[3] = '{1, 254, 1'b0, 127, 1, 1'b0, 16'h0100};
    tbl[4] = '{3, 200, 1'b0, 256, 3, 1'b1, 16'h0100};
    tbl[5] = '{2, 3, 1'b1, 4, 2, 1'b0, 16'h0100};
    tbl[6] = '{7, 2, 1'b0, 7, 5, 1'b0, 16'h0100};
    tbl[7] = '{2, 255, 1'b0, 256, 2, 1'b0, 16'h0100};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset outputs",
        32'({wr_en, busy, capture_done, overflow, line_count,
             word_count, wr_addr}), 32'd0);
    chk("reset data", 32'(wr_data), 32'd0);

    arm();
    repeat (20) @(negedge clk);
    chk("armed busy", 32'(busy), 32'd1);
    chk("armed no write", 32'(got_q.size()), 32'd0);

    // Armed frame must be the table's first frame
    foreach (tbl[k]) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      if (k != 0) arm();
      load_uniform(tbl[k].nl, tbl[k].len);
      run_frame(tbl[k].open_end, -1);
      check_frame(nm);
      chk({nm, " tbl words"}, 32'(word_count), 32'(tbl[k].exp_words));
      chk({nm, " tbl lines"}, 32'(line_count), 32'(tbl[k].exp_lines));
      chk({nm, " tbl ovf"}, 32'(overflow), 32'(tbl[k].exp_ovf));
      chk({nm, " w0"}, 32'(got_q.size() > 0 ? got_q[0][15:0] : 16'hDEAD),
          32'(tbl[k].exp_w0));
      chk({nm, " last addr"},
          32'(got_q.size() > 0 ? got_q[got_q.size()-1][AW+15:16] : 0),
          32'(tbl[k].exp_words - 1));
    end
    load_uniform(2, 255);
    chk("flush word 127", 32'(got_q.size() > 127 ? got_q[127] : 0),
        32'({8'd127, 16'h00FE}));

    // Trigger while a frame is already running: that frame is skipped
    cvsync = 1'b1;
    blank();
    pix(8'h11, 1'b1);
    pix(8'h22, 1'b1);
    capture_trigger = 1'b1;
    pix(8'h33, 1'b1);
    capture_trigger = 1'b0;
    got_q.delete();
    pix(8'h44, 1'b1);
    pix(8'h55, 1'b1);
    blank();
    cvsync = 1'b0;
    blank();
    blank();
    chk("skip busy", 32'(busy), 32'd1);
    chk("skip no write", 32'(got_q.size()), 32'd0);
    load_uniform(2, 6);
    run_frame(1'b0, -1);
    check_frame("skip next");

    // Extra trigger during capture is ignored; re-arm restarts at zero
    arm();
    load_random();
    run_frame(1'b0, 1);
    check_frame("retrig");
    arm();
    chk("rearm done clr", 32'(capture_done), 32'd0);
    chk("rearm wc clr", 32'(word_count), 32'd0);
    load_random();
    run_frame(1'b0, -1);
    check_frame("rearm frame");

    for (int r = 0; r < 8; r++) begin
      arm();
      load_random();
      run_frame(r[0], -1);
      check_frame($sformatf("rand%0d", r));
    end

    // Reset in the middle of a line aborts the capture
    arm();
    cvsync = 1'b1;
    blank();
    blank();
    for (int j = 0; j < 5; j++) pix(8'(j + 8'h40), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset outputs",
        32'({wr_en, busy, capture_done, overflow, line_count,
             word_count, wr_addr}), 32'd0);
    chk("midreset data", 32'(wr_data), 32'd0);
    got_q.delete();
    for (int j = 0; j < 5; j++) pix(8'(j), 1'b1);
    blank();
    cvsync = 1'b0;
    blank();
    cvsync = 1'b1;
    pix(8'h01, 1'b1);
    pix(8'h02, 1'b1);
    blank();
    cvsync = 1'b0;
    blank();
    chk("post reset no write", 32'(got_q.size()), 32'd0);
    chk("post reset idle", 32'({busy, capture_done}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
